// File: rtl/fdsti_sched_pkg.sv
// Shared widths, descriptor field offsets and scheduler state encoding for the
// FDSTI descriptor scheduler.
package fdsti_sched_pkg;

  localparam int FDSSI_W = 12;
  localparam int SSI_W   = 8;
  localparam int STI_W   = 8;
  localparam int CNT_W   = 8;
  localparam int INFO_W  = FDSSI_W + SSI_W + STI_W + CNT_W;

  // Descriptor layout {FDSSI, SSI, STI, CNT}, CNT in the LSBs
  localparam int CNT_OFF   = 0;
  localparam int STI_OFF   = CNT_W;
  localparam int SSI_OFF   = CNT_W + STI_W;
  localparam int FDSSI_OFF = CNT_W + STI_W + SSI_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XFER = 2'd2
  } state_e;

endpackage

// File: rtl/fdsti_info_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the lowest set request strictly after ptr,
// wrapping modulo N, found by masking a doubled copy of the request vector.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] msk;
  logic [2*N-1:0] masked;
  logic           found;

  always_comb begin
    dbl    = {req, req};
    msk    = {(2*N){1'b1}} << (int'(ptr) + 1);
    masked = dbl & msk;
    found  = 1'b0;
    idx    = '0;
    // The upper copy guarantees every request in ptr+1 .. ptr+N is seen
    for (int i = 0; i < 2*N; i++) begin
      if (masked[i] && !found) begin
        found = 1'b1;
        idx   = i[W-1:0];
      end
    end
    gnt = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/fdsti_info_scheduler.sv
// Round-robin drain of the per-lane block-descriptor FIFOs: pops one descriptor,
// issues it as a reader command and checks the beat count at the block's tlast.
module fdsti_info_scheduler
  import fdsti_sched_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*INFO_W-1:0] s_info,
  input  logic [LANES-1:0]        s_info_tvalid,
  output logic [LANES-1:0]        s_info_tready,
  input  logic [LANES-1:0]        lane_enable,
  output logic                    m_cmd_tvalid,
  input  logic                    m_cmd_tready,
  output logic [LANE_W-1:0]       m_cmd_lane,
  output logic [FDSSI_W-1:0]      m_cmd_fdssi,
  output logic [SSI_W-1:0]        m_cmd_ssi,
  output logic [STI_W-1:0]        m_cmd_sti,
  output logic [CNT_W-1:0]        m_cmd_len,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  input  logic                    mon_tlast,
  output logic                    busy,
  output logic                    err_len,
  output logic [LANE_W-1:0]       err_lane,
  output logic                    err_stray
);

  logic [LANES-1:0]   req;
  logic [LANES-1:0]   gnt;
  logic [LANE_W-1:0]  gidx;
  logic [INFO_W-1:0]  sel_info;
  logic               beat;
  logic [CNT_W-1:0]   cnt_next;

  state_e             state_q, state_d;
  logic [LANE_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [FDSSI_W-1:0] fdssi_q, fdssi_d;
  logic [SSI_W-1:0]   ssi_q, ssi_d;
  logic [STI_W-1:0]   sti_q, sti_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               busy_q, busy_d;
  logic               err_len_q, err_len_d;
  logic [LANE_W-1:0]  err_lane_q, err_lane_d;
  logic               err_stray_q, err_stray_d;

  rr_arbiter #(.N(LANES), .W(LANE_W)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gidx)
  );

  assign req      = s_info_tvalid & lane_enable;
  assign beat     = mon_tvalid & mon_tready;
  assign sel_info = s_info[int'(gidx)*INFO_W +: INFO_W];
  assign cnt_next = cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    lane_d        = lane_q;
    fdssi_d       = fdssi_q;
    ssi_d         = ssi_q;
    sti_d         = sti_q;
    len_d         = len_q;
    err_lane_d    = err_lane_q;
    err_len_d     = 1'b0;
    err_stray_d   = 1'b0;
    s_info_tready = '0;
    unique case (state_q)
      IDLE: begin
        err_stray_d = beat;
        if (|req) begin
          s_info_tready = gnt;
          lane_d        = gidx;
          fdssi_d       = sel_info[FDSSI_OFF +: FDSSI_W];
          ssi_d         = sel_info[SSI_OFF +: SSI_W];
          sti_d         = sel_info[STI_OFF +: STI_W];
          len_d         = sel_info[CNT_OFF +: CNT_W];
          state_d       = CMD;
        end
      end
      CMD: begin
        // A beat in the accept cycle precedes the block and is not counted
        err_stray_d = beat;
        if (m_cmd_tready) begin
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (beat) begin
          cnt_d = cnt_next;
          if (mon_tlast) begin
            if (cnt_next != len_q) begin
              err_len_d  = 1'b1;
              err_lane_d = lane_q;
            end
            ptr_d   = lane_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_valid_d = (state_d == CMD);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= LANE_W'(LANES - 1);
      cnt_q       <= '0;
      lane_q      <= '0;
      fdssi_q     <= '0;
      ssi_q       <= '0;
      sti_q       <= '0;
      len_q       <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_len_q   <= 1'b0;
      err_lane_q  <= '0;
      err_stray_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      fdssi_q     <= fdssi_d;
      ssi_q       <= ssi_d;
      sti_q       <= sti_d;
      len_q       <= len_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      err_len_q   <= err_len_d;
      err_lane_q  <= err_lane_d;
      err_stray_q <= err_stray_d;
    end
  end

  assign m_cmd_tvalid = cmd_valid_q;
  assign m_cmd_lane   = lane_q;
  assign m_cmd_fdssi  = fdssi_q;
  assign m_cmd_ssi    = ssi_q;
  assign m_cmd_sti    = sti_q;
  assign m_cmd_len    = len_q;
  assign busy         = busy_q;
  assign err_len      = err_len_q;
  assign err_lane     = err_lane_q;
  assign err_stray    = err_stray_q;

endmodule

// File: tb/tb_fdsti_info_scheduler.sv
// Bench for fdsti_info_scheduler: per-lane descriptor FIFO model, scripted reader,
// and a scoreboard of expected commands in grant order.
module tb_fdsti_info_scheduler;

  localparam int LANES = 4;
  localparam int IW    = 36;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [LANES*IW-1:0]   s_info = '0;
  logic [LANES-1:0]      s_info_tvalid = '0;
  logic [LANES-1:0]      s_info_tready;
  logic [LANES-1:0]      lane_enable = 4'hF;
  logic                  m_cmd_tvalid;
  logic                  m_cmd_tready = 1'b1;
  logic [1:0]            m_cmd_lane;
  logic [11:0]           m_cmd_fdssi;
  logic [7:0]            m_cmd_ssi;
  logic [7:0]            m_cmd_sti;
  logic [7:0]            m_cmd_len;
  logic                  mon_tvalid = 1'b0;
  logic                  mon_tready = 1'b0;
  logic                  mon_tlast = 1'b0;
  logic                  busy;
  logic                  err_len;
  logic [1:0]            err_lane;
  logic                  err_stray;

  int n_vec = 0;
  int n_err = 0;
  logic [IW-1:0]   lq[LANES][$];
  logic [IW+1:0]   exp_q[$];
  logic [LANES-1:0] allowed = 4'hF;
  int pop_cnt[LANES];

  fdsti_info_scheduler #(.LANES(4), .LANE_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_info        (s_info),
    .s_info_tvalid (s_info_tvalid),
    .s_info_tready (s_info_tready),
    .lane_enable   (lane_enable),
    .m_cmd_tvalid  (m_cmd_tvalid),
    .m_cmd_tready  (m_cmd_tready),
    .m_cmd_lane    (m_cmd_lane),
    .m_cmd_fdssi   (m_cmd_fdssi),
    .m_cmd_ssi     (m_cmd_ssi),
    .m_cmd_sti     (m_cmd_sti),
    .m_cmd_len     (m_cmd_len),
    .mon_tvalid    (mon_tvalid),
    .mon_tready    (mon_tready),
    .mon_tlast     (mon_tlast),
    .busy          (busy),
    .err_len       (err_len),
    .err_lane      (err_lane),
    .err_stray     (err_stray)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [11:0] f, input logic [7:0] s,
                                       input logic [7:0] t, input logic [7:0] c);
    return {f, s, t, c};
  endfunction

  task automatic drive_inputs();
    logic [LANES*IW-1:0] d = '0;
    logic [LANES-1:0]    v = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lq[i].size() != 0) begin
        v[i] = 1'b1;
        d[i*IW +: IW] = lq[i][0];
      end
    end
    s_info        = d;
    s_info_tvalid = v;
  endtask

  task automatic load(input int lane, input logic [IW-1:0] d, input bit expect_cmd);
    lq[lane].push_back(d);
    if (expect_cmd) exp_q.push_back({2'(lane), d});
  endtask

  // FIFO model: inputs refresh on the falling edge, pops are taken on the rising edge
  always @(negedge clk) drive_inputs();

  always @(posedge clk) begin : pop_mon
    logic [LANES-1:0] vld;
    if (!rst && s_info_tready != '0) begin
      for (int i = 0; i < LANES; i++) vld[i] = (lq[i].size() != 0);
      chk("pop_onehot", 64'($onehot(s_info_tready)), 1);
      chk("pop_mask", s_info_tready & ~allowed, 0);
      chk("pop_valid", s_info_tready & ~vld, 0);
      for (int i = 0; i < LANES; i++) begin
        if (s_info_tready[i] && lq[i].size() != 0) begin
          lq[i].delete(0);
          pop_cnt[i]++;
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      lq[i].delete();
      pop_cnt[i] = 0;
    end
    exp_q.delete();
    mon_tvalid   = 1'b0;
    mon_tready   = 1'b0;
    mon_tlast    = 1'b0;
    lane_enable  = 4'hF;
    allowed      = 4'hF;
    m_cmd_tready = 1'b1;
    drive_inputs();
    #1;
    chk("rst_outputs", {s_info_tready, m_cmd_tvalid, m_cmd_lane, m_cmd_fdssi, m_cmd_ssi,
                        m_cmd_sti, m_cmd_len, busy, err_len, err_lane, err_stray}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cmd(output bit ok);
    int t = 0;
    while (!m_cmd_tvalid && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = m_cmd_tvalid;
  endtask

  task automatic serve(input int nbeats, input bit exp_err, input logic [1:0] exp_lane);
    bit ok;
    logic [IW+1:0] e;
    wait_cmd(ok);
    if (!ok) begin
      chk("cmd_timeout", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("cmd_unexpected", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("cmd_lane", m_cmd_lane, e[IW+1:IW]);
    chk("cmd_fields", {m_cmd_fdssi, m_cmd_ssi, m_cmd_sti, m_cmd_len}, e[IW-1:0]);
    @(negedge clk);
    for (int b = 1; b <= nbeats; b++) begin
      mon_tvalid = 1'b1;
      mon_tready = 1'b1;
      mon_tlast  = (b == nbeats);
      @(negedge clk);
    end
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
    chk("err_len", err_len, exp_err);
    if (exp_err) chk("err_lane", err_lane, exp_lane);
    chk("stray_in_xfer", err_stray, 0);
    @(negedge clk);
    chk("err_len_pulse", err_len, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    logic [IW+1:0] e;
    @(negedge clk);

    // 1: single lane, latency and field transport
    apply_reset();
    load(2, mk(12'hABC, 8'h12, 8'h34, 8'd5), 1);
    drive_inputs();
    #1;
    chk("t1_pop_same_cycle", s_info_tready, 4'b0100);
    chk("t1_no_cmd_yet", m_cmd_tvalid, 0);
    @(negedge clk);
    chk("t1_cmd_next_cycle", m_cmd_tvalid, 1);
    chk("t1_pop_one_cycle", s_info_tready, 0);
    chk("t1_busy", busy, 1);
    serve(5, 0, 0);
    chk("t1_busy_fall", busy, 0);

    // 2: all lanes, three single-beat blocks each, strict rotation
    apply_reset();
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < LANES; l++)
        load(l, mk(12'(12'h100 + 16*l + k), 8'(8'h20 + l), 8'(8'h40 + k), 8'd1), 1);
    drive_inputs();
    for (int n = 0; n < 12; n++) serve(1, 0, 0);

    // 3: only odd lanes enabled
    apply_reset();
    lane_enable = 4'b1010;
    allowed     = 4'b1010;
    for (int k = 0; k < 2; k++)
      for (int l = 0; l < LANES; l++)
        load(l, mk(12'(12'h300 + 16*l + k), 8'h55, 8'(k), 8'd1), (l % 2) == 1);
    drive_inputs();
    for (int n = 0; n < 4; n++) serve(1, 0, 0);
    repeat (3) @(negedge clk);
    chk("t3_idle_after", m_cmd_tvalid, 0);
    chk("t3_lane0_pops", pop_cnt[0], 0);
    chk("t3_lane2_pops", pop_cnt[2], 0);
    chk("t3_lane1_pops", pop_cnt[1], 2);

    // 4: short block flags the lane, next block is clean
    apply_reset();
    load(3, mk(12'h444, 8'h44, 8'h44, 8'd4), 1);
    drive_inputs();
    serve(3, 1, 2'd3);
    load(0, mk(12'h011, 8'h22, 8'h33, 8'd2), 1);
    drive_inputs();
    serve(2, 0, 0);
    chk("t4_err_lane_hold", err_lane, 3);

    // 5: zero length means a full 256-beat block
    apply_reset();
    load(2, mk(12'hF00, 8'hA5, 8'h5A, 8'd0), 1);
    load(2, mk(12'hF01, 8'hA6, 8'h5B, 8'd0), 1);
    drive_inputs();
    serve(256, 0, 0);
    serve(255, 1, 2'd2);

    // 6: stalled command, stray beats and reset mid-transfer
    apply_reset();
    m_cmd_tready = 1'b0;
    load(1, mk(12'h5A5, 8'h66, 8'h77, 8'd3), 1);
    drive_inputs();
    wait_cmd(ok);
    chk("t6_cmd_seen", ok, 1);
    e = exp_q.pop_front();
    chk("t6_cmd", {m_cmd_lane, m_cmd_fdssi, m_cmd_ssi, m_cmd_sti, m_cmd_len}, e);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      load(2 + (c % 2), mk(12'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)), 0);
      lane_enable = 4'($urandom);
      drive_inputs();
      chk("t6_hold_valid", m_cmd_tvalid, 1);
      chk("t6_hold", {m_cmd_lane, m_cmd_fdssi, m_cmd_ssi, m_cmd_sti, m_cmd_len}, e);
    end
    lane_enable  = 4'hF;
    m_cmd_tready = 1'b1;
    mon_tvalid   = 1'b1;
    mon_tready   = 1'b1;
    mon_tlast    = 1'b0;
    @(negedge clk);
    chk("t6_stray_at_accept", err_stray, 1);
    @(negedge clk);
    chk("t6_no_stray_xfer", err_stray, 0);
    chk("t6_busy_xfer", busy, 1);
    apply_reset();
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    @(negedge clk);
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    chk("t6_stray_idle", err_stray, 1);
    @(negedge clk);
    chk("t6_stray_pulse", err_stray, 0);
    load(0, mk(12'h0A0, 8'h0B, 8'h0C, 8'd2), 1);
    load(1, mk(12'h1A1, 8'h1B, 8'h1C, 8'd1), 1);
    drive_inputs();
    serve(2, 0, 0);
    serve(1, 0, 0);
    chk("t6_scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
